// File: rtl/watchdog_module_if.sv
// Control/status bundle between the watchdog and the logic that kicks and configures it.
// The watchdog sits on the slave side; the kicking agent is the master.
interface watchdog_module_if #(
    parameter int CNT_W = 16
);
    logic             wdt_en;
    logic             kick;
    logic [7:0]       kick_key;
    logic             cfg_we;
    logic [CNT_W-1:0] cfg_timeout;
    logic [CNT_W-1:0] count;
    logic             warn;
    logic             wdt_reset;
    logic             bad_kick;
    logic [7:0]       fire_cnt;

    modport master (
        output wdt_en, kick, kick_key, cfg_we, cfg_timeout,
        input  count, warn, wdt_reset, bad_kick, fire_cnt
    );

    modport slave (
        input  wdt_en, kick, kick_key, cfg_we, cfg_timeout,
        output count, warn, wdt_reset, bad_kick, fire_cnt
    );
endinterface

// File: rtl/watchdog_module.sv
// Keyed watchdog timer: missed or bad kicks raise a PULSE_LEN-cycle reset request.
// Build with WDT_WINDOW_EN to also reject valid-key kicks arriving while count > WINDOW.
module watchdog_module #(
    parameter int               CNT_W           = 16,
    parameter logic [CNT_W-1:0] DEFAULT_TIMEOUT = 16'hFFFF,
    parameter logic [CNT_W-1:0] WARN_LEVEL      = 16'h00FF,
    parameter int               PULSE_LEN       = 16,
    parameter logic [7:0]       KEY             = 8'hA5,
    parameter logic [CNT_W-1:0] WINDOW          = 16'h0100
) (
    input  logic              clk,
    input  logic              areset,
    watchdog_module_if.slave  bus
);
    // Bit 1 marks the pulse states so wdt_reset is a single flop output.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIRE = 2'b10,
        S_HOLD = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic [7:0]       pulse_q, pulse_d;
    logic [7:0]       fire_cnt_q, fire_cnt_d;
    logic             bad_kick_q, bad_kick_d;
    logic             early;
    logic             kick_good, kick_bad;

`ifdef WDT_WINDOW_EN
    assign early = (count_q > WINDOW);
`else
    logic unused_window;
    assign unused_window = ^WINDOW;
    assign early = 1'b0;
`endif

    assign kick_bad  = bus.kick && ((bus.kick_key != KEY) || early);
    assign kick_good = bus.kick && (bus.kick_key == KEY);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q    <= S_IDLE;
            count_q    <= DEFAULT_TIMEOUT;
            reload_q   <= DEFAULT_TIMEOUT;
            pulse_q    <= 8'd0;
            fire_cnt_q <= 8'd0;
            bad_kick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            reload_q   <= reload_d;
            pulse_q    <= pulse_d;
            fire_cnt_q <= fire_cnt_d;
            bad_kick_q <= bad_kick_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pulse_d    = pulse_q;
        fire_cnt_d = fire_cnt_q;
        bad_kick_d = 1'b0;
        // A reload on the same edge as cfg_we must see the new clamped value.
        reload_d   = reload_q;
        if (bus.cfg_we)
            reload_d = (bus.cfg_timeout == '0) ? CNT_W'(1) : bus.cfg_timeout;

        case (state_q)
            S_IDLE: begin
                count_d = reload_d;
                if (bus.wdt_en)
                    state_d = S_RUN;
            end
            S_RUN: begin
                if (!bus.wdt_en) begin
                    state_d = S_IDLE;
                    count_d = reload_d;
                end else if (kick_bad) begin
                    bad_kick_d = 1'b1;
                    state_d    = S_FIRE;
                end else if (kick_good) begin
                    count_d = reload_d;
                end else if (count_q == '0) begin
                    state_d = S_FIRE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            S_FIRE: begin
                fire_cnt_d = (fire_cnt_q == 8'hFF) ? 8'hFF : fire_cnt_q + 8'd1;
                pulse_d    = 8'(PULSE_LEN - 1);
                if (PULSE_LEN == 1) begin
                    state_d = S_IDLE;
                    count_d = reload_d;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                pulse_d = pulse_q - 8'd1;
                if (pulse_q <= 8'd1) begin
                    state_d = S_IDLE;
                    count_d = reload_d;
                end
            end
        endcase
    end

    always_comb begin
        bus.count     = count_q;
        bus.warn      = (state_q == S_RUN) && (count_q <= WARN_LEVEL);
        bus.wdt_reset = state_q[1];
        bus.bad_kick  = bad_kick_q;
        bus.fire_cnt  = fire_cnt_q;
    end
endmodule
